// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state type, read-latency limits and byte parity helper for sram_pipe_bank
package sram_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  function automatic logic parity8(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/sram_pipe_bank_if.sv
// sram_pipe_bank_if: request (valid/ready/we/addr/wdata/be), response (valid/ready/rdata/perr) and init_done bundle; master = requester, slave = bank
interface sram_pipe_bank_if #(parameter int DATA_W = 8, parameter int ADDR_W = 10);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_be;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_perr;
  logic init_done;
  modport master(
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_perr, init_done
  );
  modport slave(
    input req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_perr, init_done
  );
endinterface

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: synchronous FIFO (clk, rst, push/din, pop/dout, valid); dout reads zero when empty
module sram_rsp_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp, wp_n, rp_n;
  logic [CW-1:0] cnt;
  logic do_pop;
  assign valid = cnt != '0;
  assign do_pop = pop && valid;
  assign dout = valid ? mem[rp] : '0;
  assign wp_n = wp == PW'(DEPTH - 1) ? '0 : wp + PW'(1);
  assign rp_n = rp == PW'(DEPTH - 1) ? '0 : rp + PW'(1);
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp_n;
      end
      if (do_pop) rp <= rp_n;
      cnt <= push && !do_pop ? cnt + CW'(1) : !push && do_pop ? cnt - CW'(1) : cnt;
    end
  assert property (@(posedge clk) disable iff (rst) !(push && !do_pop && cnt == CW'(DEPTH)));
endmodule

// File: rtl/sram_pipe_bank.sv
// sram_pipe_bank: SRAM bank (clk, reset, bus: valid/ready requests, byte-enabled writes, RD_LAT read pipe, credit-limited response FIFO, zero-init sweep); SRAM_PARITY_EN adds per-byte parity
module sram_pipe_bank
  import sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2,
  parameter int RSP_DEPTH = RD_LAT + 1
) (
  input logic clk,
  input logic reset,
  sram_pipe_bank_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int W = DATA_W + 1;
  state_t state, state_n;
  logic [ADDR_W-1:0] init_addr;
  logic [CW-1:0] credits;
  logic [DATA_W-1:0] mem [DEPTH];
  logic acc, wr_acc, rd_acc, pop, rd_perr;
  logic [RD_LAT-1:0] pipe_v;
  logic [W-1:0] pipe_d [RD_LAT];
  logic [W-1:0] fifo_dout;
  assign bus.req_ready = state == ST_RUN && (bus.req_we || credits != '0);
  assign acc = bus.req_valid && bus.req_ready;
  assign wr_acc = acc && bus.req_we;
  assign rd_acc = acc && !bus.req_we;
  assign pop = bus.rsp_valid && bus.rsp_ready;
  assign bus.init_done = state == ST_RUN;
  always_comb state_n = state == ST_INIT && init_addr == ADDR_W'(DEPTH - 1) ? ST_RUN : state;
  always_ff @(posedge clk) begin
    state <= reset ? ST_INIT : state_n;
    init_addr <= reset ? '0 : state == ST_INIT ? init_addr + ADDR_W'(1) : init_addr;
    credits <= reset ? CW'(RSP_DEPTH) :
               rd_acc && !pop ? credits - CW'(1) :
               pop && !rd_acc ? credits + CW'(1) : credits;
  end
`ifdef SRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  always_ff @(posedge clk)
    if (!reset && state == ST_INIT) begin
      mem[init_addr] <= '0;
      par[init_addr] <= '0;
    end else if (!reset && wr_acc)
      for (int i = 0; i < NB; i++)
        if (bus.req_be[i]) begin
          mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
          par[bus.req_addr][i] <= parity8(bus.req_wdata[8*i +: 8]);
        end
  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < NB; i++)
      rd_perr = rd_perr | (par[bus.req_addr][i] != parity8(mem[bus.req_addr][8*i +: 8]));
  end
`else
  always_ff @(posedge clk)
    if (!reset && state == ST_INIT) mem[init_addr] <= '0;
    else if (!reset && wr_acc)
      for (int i = 0; i < NB; i++)
        if (bus.req_be[i]) mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
  assign rd_perr = 1'b0;
`endif
  // Stage 0 samples the array at acceptance; the last stage pushes into the FIFO RD_LAT edges later.
  always_ff @(posedge clk) begin
    pipe_v <= reset ? '0 : (pipe_v << 1) | RD_LAT'(rd_acc);
    pipe_d[0] <= {rd_perr, mem[bus.req_addr]};
    for (int k = 1; k < RD_LAT; k++) pipe_d[k] <= pipe_d[k-1];
  end
  sram_rsp_fifo #(.W(W), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(pipe_v[RD_LAT-1]),
    .pop(pop),
    .din(pipe_d[RD_LAT-1]),
    .dout(fifo_dout),
    .valid(bus.rsp_valid)
  );
  assign bus.rsp_rdata = fifo_dout[DATA_W-1:0];
  assign bus.rsp_perr = fifo_dout[DATA_W];
  assert property (@(posedge clk) RD_LAT >= RD_LAT_MIN && RD_LAT <= RD_LAT_MAX && DATA_W % 8 == 0);
endmodule

// File: tb/tb_sram_pipe_bank.sv
// tb_sram_pipe_bank: directed stimulus with a response scoreboard for sram_pipe_bank (DATA_W=16, ADDR_W=4, RD_LAT=2)
module tb_sram_pipe_bank;
  localparam int DW = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [DW:0] sb [$];
  logic [DW:0] mon_e;
  sram_pipe_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  sram_pipe_bank #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .RSP_DEPTH(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [1:0] be, input logic [DW:0] exp);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_be = be;
    forever begin
      @(negedge clk);
      if (bus.req_ready || n > 40) break;
      n++;
    end
    check("req_accept", 32'(n <= 40), 32'd1);
    if (n <= 40) begin
      @(posedge clk);
      if (!we) sb.push_back(exp);
    end
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic wait_init();
    int n = 0;
    while (!bus.init_done && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("init_cycles", 32'(n), 32'd16);
  endtask
  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got %0h expected no response", bus.rsp_rdata);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_e[DW-1:0]));
        check("rsp_perr", 32'(bus.rsp_perr), 32'(mon_e[DW]));
      end
    end
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_be = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_rsp_perr", 32'(bus.rsp_perr), 32'd0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_init();
    for (int a = 0; a < 16; a++) send(1'b0, AW'(a), '0, 2'b00, '0);
    wait_drain();
    send(1'b1, 4'd1, 16'h00AA, 2'b11, '0);
    send(1'b0, 4'd1, '0, 2'b00, {1'b0, 16'h00AA});
    @(negedge clk);
    @(negedge clk);
    check("lat_early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("lat_on_time", 32'(bus.rsp_valid), 32'd1);
    wait_drain();
    send(1'b1, 4'd3, 16'h55AA, 2'b11, '0);
    send(1'b1, 4'd3, 16'h1234, 2'b10, '0);
    send(1'b0, 4'd3, '0, 2'b00, {1'b0, 16'h12AA});
    send(1'b1, 4'd3, 16'hFFFF, 2'b00, '0);
    send(1'b0, 4'd3, '0, 2'b00, {1'b0, 16'h12AA});
    wait_drain();
    bus.rsp_ready = 1'b0;
    send(1'b0, 4'd1, '0, 2'b00, {1'b0, 16'h00AA});
    send(1'b0, 4'd3, '0, 2'b00, {1'b0, 16'h12AA});
    send(1'b0, 4'd0, '0, 2'b00, {1'b0, 16'h0000});
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 4'd2;
    repeat (3) begin
      @(negedge clk);
      check("rd_blocked", 32'(bus.req_ready), 32'd0);
      check("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("rsp_hold_data", 32'(bus.rsp_rdata), 32'h00AA);
    end
    @(posedge clk);
    #1;
    send(1'b1, 4'd7, 16'hBEEF, 2'b11, '0);
    bus.rsp_ready = 1'b1;
    wait_drain();
    send(1'b0, 4'd7, '0, 2'b00, {1'b0, 16'hBEEF});
    wait_drain();
    send(1'b0, 4'd1, '0, 2'b00, {1'b0, 16'h00AA});
    send(1'b0, 4'd3, '0, 2'b00, {1'b0, 16'h12AA});
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    check("rst_flush_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_flush_init", 32'(bus.init_done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_init();
    send(1'b0, 4'd3, '0, 2'b00, '0);
    send(1'b0, 4'd7, '0, 2'b00, '0);
    send(1'b0, 4'd0, '0, 2'b00, '0);
    wait_drain();
`ifdef SRAM_PARITY_EN
    send(1'b1, 4'd5, 16'h0F0F, 2'b11, '0);
    dut.mem[5][0] = ~dut.mem[5][0];
    send(1'b0, 4'd5, '0, 2'b00, {1'b1, 16'h0F0E});
    send(1'b1, 4'd6, 16'h3C00, 2'b10, '0);
    send(1'b0, 4'd6, '0, 2'b00, {1'b0, 16'h3C00});
`else
    send(1'b1, 4'd5, 16'h0F0F, 2'b11, '0);
    send(1'b0, 4'd5, '0, 2'b00, {1'b0, 16'h0F0F});
`endif
    wait_drain();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_pipe_bank.md
Name: sram_pipe_bank

Overview:
- Parametrised single-port SRAM bank. It succeeds the fixed 1K x 8 SRAM and supersedes it.
- Adds a valid/ready request interface, byte-enabled writes, a configurable read pipeline latency, a backpressured response queue, and a post-reset zero-initialisation sweep.
- Sits between a requester (core/DMA) and the memory array. One request per cycle, responses returned in order.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 10, address width; depth = 2**ADDR_W words.
- RD_LAT, 2, cycles from read acceptance to rsp_valid; legal range 1..4.
- RSP_DEPTH, RD_LAT+1, response queue entries (read-credit limit).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  bank accepts request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes; ignored for reads
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  read data
- rsp_perr  out  1  parity error flag for rsp_rdata
- init_done  out  1  zero-initialisation sweep complete

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_perr=0, init_done=0. The read pipeline and response queue are flushed, credits=RSP_DEPTH, FSM goes to INIT.
- FSM states: INIT -> RUN.
  - INIT: one word written to zero per cycle, address 0 up to 2**ADDR_W-1. After the last word, go to RUN and set init_done=1 the next cycle. The sweep takes exactly 2**ADDR_W cycles.
  - RUN: normal operation.
  - reset asserted in any state restarts INIT from address 0.
- Accept: a request is accepted when req_valid && req_ready. req_ready = (state==RUN) && (req_we || credits>0).
  - Writes are never blocked in RUN.
  - A read consumes one credit at acceptance. The credit is returned when the response is popped (rsp_valid && rsp_ready).
  - Credit take and return in the same cycle leave the count unchanged.
- Writes: only bytes with req_be[i]=1 are updated, at the acceptance edge. req_be=0 is a legal no-op. Writes produce no response.
- Reads: the array is sampled at the acceptance edge. Data enters the response queue RD_LAT cycles later.
  - With an empty queue and rsp_ready=1, rsp_valid rises exactly RD_LAT cycles after acceptance.
  - A read accepted the cycle after a write to the same address returns the new data. A read and write cannot coincide, since there is one request per cycle.
- Response queue: FIFO of RSP_DEPTH entries; rsp_rdata/rsp_valid come from the head.
  - Holding rsp_ready=0 keeps rsp_rdata stable.
  - The credit scheme guarantees no overflow. Overflow is an assertion failure.
- Back-to-back reads sustain 1 per cycle while rsp_ready=1.
- Address arithmetic: req_addr is used directly with no wrap logic; all 2**ADDR_W values are legal.

Optional Feature:
- SRAM_PARITY_EN defined:
  - The array stores one even-parity bit per byte, computed on write. The INIT sweep writes parity=0.
  - On read, rsp_perr=1 if any byte's stored parity mismatches its data. The flag is queued alongside the data.
  - A write with partial req_be updates parity only for the written bytes.
- Not defined: no parity storage, and rsp_perr is tied to 0.

Decomposition:
- Shared package sram_pkg: state enum (ST_INIT, ST_RUN), RD_LAT legal-range constants, parity function.
- Natural sub-module: sram_rsp_fifo, the parametrised synchronous FIFO for the response queue, with data+perr width and RSP_DEPTH entries.

Test Plan:
- Reset then idle, DATA_W=8, ADDR_W=4 -> init_done rises 16 cycles after reset deasserts. Reads of addresses 0..15 all return 8'h00.
- Write addr 1 = 8'hAA, then read addr 1, RD_LAT=2, rsp_ready=1 -> rsp_rdata=8'hAA with rsp_valid exactly 2 cycles after read acceptance.
- DATA_W=16: write 16'h55AA to addr 3, then write 16'h1234 with req_be=2'b10 -> read returns 16'h12AA.
- Hold rsp_ready=0 and issue reads continuously -> exactly RSP_DEPTH=3 reads accepted, then req_ready=0 for reads. Writes still accepted. Releasing rsp_ready drains 3 responses in order.
- Assert reset mid-stream with 2 reads in flight -> rsp_valid=0 the next cycle, no stale response ever appears, INIT restarts at address 0.
- With SRAM_PARITY_EN, force-flip one stored bit of addr 5 -> read of addr 5 gives rsp_perr=1. Without the macro, rsp_perr stays 0.
